// File: rtl/ite_fifo_pkg.sv
// Shared definitions for the if-then-else result FIFO: default sizing and
// pointer-width helper used by the top level and the pointer counters.
package ite_fifo_pkg;

    localparam int DEFAULT_WIDTH = 3;
    localparam int DEFAULT_DEPTH = 4;

    // One extra MSB beyond the index bits distinguishes full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [ptr_w(DEFAULT_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/ite_fifo_ptr.sv
// Free-running FIFO pointer: advances on inc and wraps naturally at 2*DEPTH
// because its width is exactly clog2(DEPTH)+1 bits.
module ite_fifo_ptr
    import ite_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      inc,
    output logic [ptr_w(DEPTH)-1:0]   ptr
);

    logic [ptr_w(DEPTH)-1:0] r_ptr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/ite_result_fifo.sv
// Show-ahead valid/ready FIFO capturing the select-stage result. Status
// outputs derive from registered pointers only, so no input-to-output paths.
module ite_result_fifo
    import ite_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH   // power of two, >= 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [WIDTH-1:0]          I,
    input  logic                      I_valid,
    output logic                      I_ready,
    output logic [WIDTH-1:0]          O,
    output logic                      O_valid,
    input  logic                      O_ready,
    output logic [ptr_w(DEPTH)-1:0]   count
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [PW-1:0]    w_wptr;
    logic [PW-1:0]    w_rptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (w_wptr == w_rptr);
    assign w_full  = (w_wptr[PW-2:0] == w_rptr[PW-2:0]) &&
                     (w_wptr[PW-1] != w_rptr[PW-1]);

    assign w_push  = I_valid && !w_full;
    assign w_pop   = O_ready && !w_empty;

    ite_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (w_push),
        .ptr   (w_wptr)
    );

    ite_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (w_pop),
        .ptr   (w_rptr)
    );

    // Storage is deliberately not reset; stale data is masked by O_valid.
    always_ff @(posedge CLK) begin
        if (w_push && !RESET) begin
            r_mem[w_wptr[PW-2:0]] <= I;
        end
    end

    assign O       = r_mem[w_rptr[PW-2:0]];
    assign O_valid = !w_empty;
    assign I_ready = !w_full;
    assign count   = w_wptr - w_rptr;

endmodule

// File: tb/tb_ite_result_fifo.sv
// Self-checking bench for ite_result_fifo: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_ite_result_fifo;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [WIDTH-1:0] I;
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] O;
    logic             O_valid;
    logic             O_ready;
    logic [CW-1:0]    count;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] model_q [$];

    ite_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .I       (I),
        .I_valid (I_valid),
        .I_ready (I_ready),
        .O       (O),
        .O_valid (O_valid),
        .O_ready (O_ready),
        .count   (count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock: the model applies the rules using pre-edge occupancy.
    task automatic tick();
        bit do_push;
        bit do_pop;
        logic [WIDTH-1:0] din;
        do_push = I_valid && (model_q.size() < DEPTH);
        do_pop  = O_ready && (model_q.size() > 0);
        din     = I;
        @(posedge CLK);
        #1;
        if (RESET) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(din);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"},   32'(count),   32'(model_q.size()));
        chk({tag, ".O_valid"}, 32'(O_valid), 32'(model_q.size() > 0));
        chk({tag, ".I_ready"}, 32'(I_ready), 32'(model_q.size() < DEPTH));
        if (model_q.size() > 0)
            chk({tag, ".O"}, 32'(O), 32'(model_q[0]));
    endtask

    task automatic step(input string tag);
        tick();
        check_state(tag);
    endtask

    task automatic idle_inputs();
        I       = '0;
        I_valid = 1'b0;
        O_ready = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        idle_inputs();

        // Reset then idle, with stray O_ready while empty
        step("rst0");
        step("rst1");
        RESET = 1'b0;
        step("rst_release");
        chk("rst.count_zero", 32'(count), 32'd0);
        O_ready = 1'b1;
        for (int k = 0; k < 3; k++) step("idle_oready");
        O_ready = 1'b0;

        // Single push of 5, then pop
        I = 3'h5; I_valid = 1'b1;
        step("push5");
        I_valid = 1'b0;
        chk("push5.O", 32'(O), 32'h5);
        chk("push5.count", 32'(count), 32'd1);
        O_ready = 1'b1;
        step("pop5");
        chk("pop5.count", 32'(count), 32'd0);
        O_ready = 1'b0;

        // Fill to full, offer a 5th value that must be refused
        for (int k = 1; k <= 4; k++) begin
            I = WIDTH'(k); I_valid = 1'b1;
            step("fill");
        end
        chk("full.I_ready", 32'(I_ready), 32'd0);
        chk("full.count", 32'(count), 32'd4);
        I = 3'h7; I_valid = 1'b1;
        step("full_hold7");
        I_valid = 1'b0;
        O_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain.O", 32'(O), 32'(k));
            step("drain");
        end
        chk("drain.empty", 32'(O_valid), 32'd0);
        O_ready = 1'b0;

        // Full with a pop and a held write of 7: write waits one cycle
        for (int k = 1; k <= 4; k++) begin
            I = WIDTH'(k); I_valid = 1'b1;
            step("refill");
        end
        I = 3'h7; I_valid = 1'b1; O_ready = 1'b1;
        step("full_pop");
        chk("full_pop.count", 32'(count), 32'd3);
        chk("full_pop.I_ready", 32'(I_ready), 32'd1);
        O_ready = 1'b0;
        step("late_push7");
        chk("late_push7.count", 32'(count), 32'd4);
        I_valid = 1'b0; O_ready = 1'b1;
        for (int k = 0; k < 4; k++) step("drain2");
        O_ready = 1'b0;

        // Streaming 0..7 with both handshakes high
        I_valid = 1'b1; O_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            I = WIDTH'(k % 8);
            step("stream");
            if (k > 0) chk("stream.O", 32'(O), 32'(k % 8));
        end
        idle_inputs();
        O_ready = 1'b1;
        step("stream_drain");
        O_ready = 1'b0;

        // Reset with three entries and a same-cycle push
        for (int k = 0; k < 3; k++) begin
            I = WIDTH'(k + 2); I_valid = 1'b1;
            step("pre_rst");
        end
        chk("pre_rst.count", 32'(count), 32'd3);
        RESET = 1'b1; I = 3'h6; I_valid = 1'b1;
        step("mid_rst");
        chk("mid_rst.count", 32'(count), 32'd0);
        chk("mid_rst.O_valid", 32'(O_valid), 32'd0);
        RESET = 1'b0; I_valid = 1'b0;
        step("post_rst");

        // Random traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            I       = WIDTH'($urandom_range(0, 7));
            I_valid = ($urandom_range(0, 3) != 0);
            O_ready = ($urandom_range(0, 3) != 0);
            RESET   = ($urandom_range(0, 59) == 0);
            step("rand");
        end
        RESET = 1'b0;
        idle_inputs();
        step("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
